// File: rtl/fanout_chk_pkg.sv
// Shared types and helpers for the fan-out settle checker.
package fanout_chk_pkg;

  // Width of a copy index and the widest fan-out the checker supports
  localparam int IDX_W      = 5;
  localparam int MAX_COPIES = 32;

  // Checker FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    ERROR  = 2'd3
  } fsm_state_e;

  // Index of the lowest set bit of a mismatch vector (0 when none is set)
  function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_COPIES-1:0] mm);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = MAX_COPIES - 1; k >= 0; k--) begin
      if (mm[k]) idx = IDX_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fanout_settle_checker_sampler.sv
// Input sampling stage: registers src and the copies, then derives the
// source-change flag and the per-copy mismatch vector from the samples.
module fanout_settle_checker_sampler #(
  parameter int                  N_COPIES = 10,
  parameter logic [N_COPIES-1:0] INV_MASK = 10'b1010101010
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_src,
  input  logic [N_COPIES-1:0] i_copies,
  output logic                o_chg,
  output logic [N_COPIES-1:0] o_mm
);

  logic                r_s_src;
  logic                r_p_src;
  logic [N_COPIES-1:0] r_s_cp;
  logic [N_COPIES-1:0] w_exp;

  // Sample the source, the copies and the previous source every cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s_src <= 1'b0;
      r_p_src <= 1'b0;
      r_s_cp  <= '0;
    end else begin
      r_s_src <= i_src;
      r_p_src <= r_s_src;
      r_s_cp  <= i_copies;
    end
  end

  assign w_exp = {N_COPIES{r_s_src}} ^ INV_MASK;
  assign o_chg = (r_s_src !== r_p_src);

  // Case-inequality so an unknown copy is flagged rather than masked
  always_comb begin
    o_mm = '0;
    for (int k = 0; k < N_COPIES; k++) begin
      o_mm[k] = (r_s_cp[k] !== w_exp[k]);
    end
  end

endmodule

// File: rtl/fanout_settle_checker.sv
// Fan-out settle checker: after every source change waits a settle window,
// then checks each registered copy against its expected polarity.
module fanout_settle_checker
  import fanout_chk_pkg::*;
#(
  parameter int                  N_COPIES      = 10,
  parameter logic [N_COPIES-1:0] INV_MASK      = 10'b1010101010,
  parameter int                  SETTLE_CYCLES = 2,
  parameter int                  CNT_W         = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_clear,
  input  logic                i_src,
  input  logic [N_COPIES-1:0] i_copies,
  output logic                o_stable,
  output logic                o_err,
  output logic [IDX_W-1:0]    o_bad_idx,
  output logic [CNT_W-1:0]    o_mismatch_cnt
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  fsm_state_e              r_state;
  fsm_state_e              w_state_nxt;
  logic [3:0]              r_settle_ctr;
  logic [3:0]              w_settle_nxt;
  logic                    r_stable;
  logic                    r_err;
  logic [IDX_W-1:0]        r_bad_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic                    w_chg;
  logic [N_COPIES-1:0]     w_mm;
  logic [MAX_COPIES-1:0]   w_mm_ext;
  logic                    w_any_mm;
  logic                    w_fail;
  logic                    w_stable_nxt;

  fanout_settle_checker_sampler #(
    .N_COPIES (N_COPIES),
    .INV_MASK (INV_MASK)
  ) u_sampler (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_src    (i_src),
    .i_copies (i_copies),
    .o_chg    (w_chg),
    .o_mm     (w_mm)
  );

  // Widen the mismatch vector to the helper's fixed width
  always_comb begin
    w_mm_ext                 = '0;
    w_mm_ext[N_COPIES-1:0]   = w_mm;
  end

  assign w_any_mm     = |w_mm;
  assign w_fail       = (r_state == CHECK) && !w_chg && w_any_mm && i_en && !i_clear;
  assign w_stable_nxt = (r_state == CHECK) && !w_chg && !w_any_mm;

  // Next-state and settle-counter logic; clear beats en, en beats the FSM
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_ctr;
    if (i_clear) begin
      w_state_nxt  = IDLE;
      w_settle_nxt = '0;
    end else if (!i_en) begin
      w_state_nxt  = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt  = SETTLE;
          w_settle_nxt = SETTLE_LOAD;
        end
        SETTLE: begin
          if (w_chg) begin
            w_settle_nxt = SETTLE_LOAD;
          end else if (r_settle_ctr == 4'd0) begin
            w_state_nxt  = CHECK;
          end else begin
            w_settle_nxt = r_settle_ctr - 4'd1;
          end
        end
        CHECK: begin
          if (w_chg) begin
            w_state_nxt  = SETTLE;
            w_settle_nxt = SETTLE_LOAD;
          end else if (w_any_mm) begin
            w_state_nxt  = ERROR;
          end
        end
        ERROR: begin
          w_state_nxt  = ERROR;
        end
        default: begin
          w_state_nxt  = IDLE;
        end
      endcase
    end
  end

  // State, flags, captured index and saturating mismatch counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_settle_ctr <= '0;
      r_stable     <= 1'b0;
      r_err        <= 1'b0;
      r_bad_idx    <= '0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_ctr <= w_settle_nxt;
      r_stable     <= w_stable_nxt;
      if (i_clear) begin
        r_err     <= 1'b0;
        r_bad_idx <= '0;
        r_cnt     <= '0;
      end else if (w_fail) begin
        r_err     <= 1'b1;
        r_bad_idx <= lowest_set(w_mm_ext);
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable       = r_stable;
  assign o_err          = r_err;
  assign o_bad_idx      = r_bad_idx;
  assign o_mismatch_cnt = r_cnt;

endmodule
